// File: rtl/riscv_decode_stage.sv
// riscv_decode_stage: registered RV32I/RV64I main-control decode stage.
//
// Decodes the instruction word from the IF/ID buffer into control bits, register indices,
// a sign-extended immediate and ALU function bits, and holds the result in a valid/ready
// pipeline register toward EX. A load-use interlock refuses the next instruction while a
// load in the EX register targets one of its source registers. A synchronous flush kills
// the held result and refuses the instruction offered in the same cycle.
//
// Parameters:
//   XLEN   datapath width (32 or 64); immediates are sign-extended to XLEN
//   RF_AW  register-file address width
//
// Ports:
//   clk, rst            core clock, asynchronous active-high reset
//   if_valid, if_ready  handshake from the IF/ID buffer
//   if_inst, if_pc      instruction word and its PC
//   flush               synchronous kill (branch mispredict / trap)
//   ex_valid, ex_ready  handshake toward EX
//   ex_pc, ex_rs1, ex_rs2, ex_rd, ex_imm, ex_funct
//                       registered decode fields; ex_funct = {inst[30], inst[14:12]}
//   ex_ctrl             {auipc, lui, regwrite, alusrc, memwrite, memtoreg, memread,
//                        branch, jal, jalr}
//   ex_illegal          unsupported opcode or inst[1:0] != 2'b11
//
// Optional feature, enabled by defining DECODE_PERF_CNT_EN:
//   perf_bubble         count of bubbles inserted by the load-use interlock
//   perf_illegal        count of accepted illegal instructions
module riscv_decode_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RF_AW = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  output logic             if_ready,
  input  logic [31:0]      if_inst,
  input  logic [XLEN-1:0]  if_pc,
  input  logic             flush,
  output logic             ex_valid,
  input  logic             ex_ready,
  output logic [XLEN-1:0]  ex_pc,
  output logic [RF_AW-1:0] ex_rs1,
  output logic [RF_AW-1:0] ex_rs2,
  output logic [RF_AW-1:0] ex_rd,
  output logic [XLEN-1:0]  ex_imm,
  output logic [3:0]       ex_funct,
  output logic [9:0]       ex_ctrl,
  output logic             ex_illegal
`ifdef DECODE_PERF_CNT_EN
  ,
  output logic [31:0]      perf_bubble,
  output logic [31:0]      perf_illegal
`endif
);

  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  // ex_ctrl bit positions
  localparam int unsigned CtrlAuipc    = 9;
  localparam int unsigned CtrlLui      = 8;
  localparam int unsigned CtrlRegwrite = 7;
  localparam int unsigned CtrlAlusrc   = 6;
  localparam int unsigned CtrlMemwrite = 5;
  localparam int unsigned CtrlMemtoreg = 4;
  localparam int unsigned CtrlMemread  = 3;
  localparam int unsigned CtrlBranch   = 2;
  localparam int unsigned CtrlJal      = 1;
  localparam int unsigned CtrlJalr     = 0;

  typedef enum logic [2:0] {ImmNone, ImmI, ImmS, ImmB, ImmU, ImmJ} imm_sel_e;

  logic [6:0]       opcode;
  logic [9:0]       ctrl;
  logic             illegal;
  logic             uses_rs1;
  logic             uses_rs2;
  imm_sel_e         imm_sel;
  logic [31:0]      imm32;
  logic [XLEN-1:0]  imm;
  logic [RF_AW-1:0] rs1;
  logic [RF_AW-1:0] rs2;
  logic [RF_AW-1:0] rd;
  logic [3:0]       funct;
  logic             hazard;
  logic             accept;

  assign opcode = if_inst[6:0];
  assign rs1    = RF_AW'(if_inst[19:15]);
  assign rs2    = RF_AW'(if_inst[24:20]);
  assign rd     = RF_AW'(if_inst[11:7]);
  assign funct  = {if_inst[30], if_inst[14:12]};

  // Main control decode. Opcodes with inst[1:0] != 2'b11 fall into the default arm.
  always_comb begin
    ctrl     = '0;
    illegal  = 1'b0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    imm_sel  = ImmNone;
    unique case (opcode)
      OpReg: begin
        ctrl[CtrlRegwrite] = 1'b1;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OpImm: begin
        ctrl[CtrlRegwrite] = 1'b1;
        ctrl[CtrlAlusrc]   = 1'b1;
        uses_rs1 = 1'b1;
        imm_sel  = ImmI;
      end
      OpLoad: begin
        ctrl[CtrlMemread]  = 1'b1;
        ctrl[CtrlMemtoreg] = 1'b1;
        ctrl[CtrlAlusrc]   = 1'b1;
        ctrl[CtrlRegwrite] = 1'b1;
        uses_rs1 = 1'b1;
        imm_sel  = ImmI;
      end
      OpStore: begin
        ctrl[CtrlMemwrite] = 1'b1;
        ctrl[CtrlAlusrc]   = 1'b1;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        imm_sel  = ImmS;
      end
      OpBranch: begin
        ctrl[CtrlBranch] = 1'b1;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        imm_sel  = ImmB;
      end
      OpJal: begin
        ctrl[CtrlJal]      = 1'b1;
        ctrl[CtrlRegwrite] = 1'b1;
        imm_sel = ImmJ;
      end
      OpJalr: begin
        ctrl[CtrlJalr]     = 1'b1;
        ctrl[CtrlAlusrc]   = 1'b1;
        ctrl[CtrlRegwrite] = 1'b1;
        uses_rs1 = 1'b1;
        imm_sel  = ImmI;
      end
      OpLui: begin
        ctrl[CtrlLui]      = 1'b1;
        ctrl[CtrlRegwrite] = 1'b1;
        ctrl[CtrlAlusrc]   = 1'b1;
        imm_sel = ImmU;
      end
      OpAuipc: begin
        ctrl[CtrlAuipc]    = 1'b1;
        ctrl[CtrlRegwrite] = 1'b1;
        ctrl[CtrlAlusrc]   = 1'b1;
        imm_sel = ImmU;
      end
      default: illegal = 1'b1;
    endcase
  end

  // Immediates are assembled as 32-bit values, then sign-extended from bit 31 to XLEN.
  always_comb begin
    imm32 = '0;
    unique case (imm_sel)
      ImmI:    imm32 = {{20{if_inst[31]}}, if_inst[31:20]};
      ImmS:    imm32 = {{20{if_inst[31]}}, if_inst[31:25], if_inst[11:7]};
      ImmB:    imm32 = {{19{if_inst[31]}}, if_inst[31], if_inst[7], if_inst[30:25],
                        if_inst[11:8], 1'b0};
      ImmU:    imm32 = {if_inst[31:12], 12'b0};
      ImmJ:    imm32 = {{11{if_inst[31]}}, if_inst[31], if_inst[19:12], if_inst[20],
                        if_inst[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = XLEN'($signed(imm32));

  // Load-use interlock: a load writing x0 never creates a dependency.
  assign hazard = if_valid & ex_valid & ex_ctrl[CtrlMemread] & (ex_rd != '0) &
                  ((uses_rs1 & (rs1 == ex_rd)) | (uses_rs2 & (rs2 == ex_rd)));

  assign if_ready = ~flush & ~hazard & (~ex_valid | ex_ready);
  assign accept   = if_valid & if_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_pc      <= '0;
      ex_rs1     <= '0;
      ex_rs2     <= '0;
      ex_rd      <= '0;
      ex_imm     <= '0;
      ex_funct   <= '0;
      ex_ctrl    <= '0;
      ex_illegal <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (accept) begin
      ex_valid   <= 1'b1;
      ex_pc      <= if_pc;
      ex_rs1     <= rs1;
      ex_rs2     <= rs2;
      ex_rd      <= rd;
      ex_imm     <= imm;
      ex_funct   <= funct;
      ex_ctrl    <= ctrl;
      ex_illegal <= illegal;
    end else if (ex_ready || !ex_valid) begin
      // Drained or idle; a hazard here becomes a single bubble.
      ex_valid <= 1'b0;
    end
  end

`ifdef DECODE_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_bubble  <= '0;
      perf_illegal <= '0;
    end else begin
      if (hazard && ex_ready && !flush) begin
        perf_bubble <= perf_bubble + 32'd1;
      end
      if (accept && illegal) begin
        perf_illegal <= perf_illegal + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_riscv_decode_stage.sv
// Self-checking bench for riscv_decode_stage at XLEN=64: a table of single-instruction
// decode vectors plus hand-written sequences for reset, streaming, load-use interlock,
// back-pressure and flush. Perf counters are checked when DECODE_PERF_CNT_EN is defined.
module tb_riscv_decode_stage;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned RF_AW = 5;

  logic             clk;
  logic             rst;
  logic             if_valid;
  logic             if_ready;
  logic [31:0]      if_inst;
  logic [XLEN-1:0]  if_pc;
  logic             flush;
  logic             ex_valid;
  logic             ex_ready;
  logic [XLEN-1:0]  ex_pc;
  logic [RF_AW-1:0] ex_rs1;
  logic [RF_AW-1:0] ex_rs2;
  logic [RF_AW-1:0] ex_rd;
  logic [XLEN-1:0]  ex_imm;
  logic [3:0]       ex_funct;
  logic [9:0]       ex_ctrl;
  logic             ex_illegal;
`ifdef DECODE_PERF_CNT_EN
  logic [31:0]      perf_bubble;
  logic [31:0]      perf_illegal;
`endif

  riscv_decode_stage #(
    .XLEN  (XLEN),
    .RF_AW (RF_AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .if_valid   (if_valid),
    .if_ready   (if_ready),
    .if_inst    (if_inst),
    .if_pc      (if_pc),
    .flush      (flush),
    .ex_valid   (ex_valid),
    .ex_ready   (ex_ready),
    .ex_pc      (ex_pc),
    .ex_rs1     (ex_rs1),
    .ex_rs2     (ex_rs2),
    .ex_rd      (ex_rd),
    .ex_imm     (ex_imm),
    .ex_funct   (ex_funct),
    .ex_ctrl    (ex_ctrl),
    .ex_illegal (ex_illegal)
`ifdef DECODE_PERF_CNT_EN
    ,
    .perf_bubble  (perf_bubble),
    .perf_illegal (perf_illegal)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [9:0]  ctrl;
    logic        ill;
    logic [63:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  funct;
  } vec_t;

  localparam int NumVec = 12;
  vec_t vecs [NumVec];

  int tests;
  int fails;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic present(input logic [31:0] inst, input logic [63:0] pc);
    if_valid = 1'b1;
    if_inst  = inst;
    if_pc    = pc;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    //            inst          ctrl    ill  imm                    rs1 rs2 rd  funct
    vecs[0]  = '{32'h00A00093, 10'h0C0, 0, 64'd10,                0,  10, 1,  4'h0}; // addi
    vecs[1]  = '{32'h002081B3, 10'h080, 0, 64'd0,                 1,  2,  3,  4'h0}; // add
    vecs[2]  = '{32'h0000A103, 10'h0D8, 0, 64'd0,                 1,  0,  2,  4'h2}; // lw
    vecs[3]  = '{32'hFE112E23, 10'h060, 0, 64'hFFFFFFFFFFFFFFFC,  2,  1,  28, 4'hA}; // sw
    vecs[4]  = '{32'hFE000EE3, 10'h004, 0, 64'hFFFFFFFFFFFFFFFC,  0,  0,  29, 4'h8}; // beq
    vecs[5]  = '{32'h800000B7, 10'h1C0, 0, 64'hFFFFFFFF80000000,  0,  0,  1,  4'h0}; // lui
    vecs[6]  = '{32'h0080006F, 10'h082, 0, 64'd8,                 0,  8,  0,  4'h0}; // jal
    vecs[7]  = '{32'hFFFFFFFF, 10'h000, 1, 64'd0,                 31, 31, 31, 4'hF}; // bad op
    vecs[8]  = '{32'h004280E7, 10'h0C1, 0, 64'd4,                 5,  4,  1,  4'h0}; // jalr
    vecs[9]  = '{32'h12345297, 10'h2C0, 0, 64'h0000000012345000,  8,  3,  5,  4'h5}; // auipc
    vecs[10] = '{32'h00000001, 10'h000, 1, 64'd0,                 0,  0,  0,  4'h0}; // [1:0]=01
    vecs[11] = '{32'h407302B3, 10'h080, 0, 64'd0,                 6,  7,  5,  4'h8}; // sub

    rst      = 1'b1;
    if_valid = 1'b0;
    if_inst  = '0;
    if_pc    = '0;
    flush    = 1'b0;
    ex_ready = 1'b0;

    // Reset values
    #2;
    check("rst ex_valid", 64'(ex_valid), 64'd0);
    check("rst ex_ctrl", 64'(ex_ctrl), 64'd0);
    check("rst ex_pc", ex_pc, 64'd0);
    check("rst ex_imm", ex_imm, 64'd0);
    check("rst ex_rd", 64'(ex_rd), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Asynchronous reset mid-cycle while a result is held
    present(32'h00A00093, 64'h80);
    @(posedge clk);
    #1 if_valid = 1'b0;
    check("hold ex_valid", 64'(ex_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("async rst ex_valid", 64'(ex_valid), 64'd0);
    check("async rst ex_ctrl", 64'(ex_ctrl), 64'd0);
    check("async rst ex_imm", ex_imm, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("post rst ex_valid", 64'(ex_valid), 64'd0);
    check("post rst ex_ctrl", 64'(ex_ctrl), 64'd0);
    ex_ready = 1'b1;

    // Decode table, one instruction at a time with an idle cycle between
    for (int i = 0; i < NumVec; i++) begin
      @(posedge clk);
      #1 present(vecs[i].inst, 64'h1000 + 64'(i * 4));
      #1 check($sformatf("v%0d if_ready", i), 64'(if_ready), 64'd1);
      @(posedge clk);
      #1 if_valid = 1'b0;
      check($sformatf("v%0d ex_valid", i), 64'(ex_valid), 64'd1);
      check($sformatf("v%0d ex_ctrl", i), 64'(ex_ctrl), 64'(vecs[i].ctrl));
      check($sformatf("v%0d ex_illegal", i), 64'(ex_illegal), 64'(vecs[i].ill));
      check($sformatf("v%0d ex_imm", i), ex_imm, vecs[i].imm);
      check($sformatf("v%0d ex_rs1", i), 64'(ex_rs1), 64'(vecs[i].rs1));
      check($sformatf("v%0d ex_rs2", i), 64'(ex_rs2), 64'(vecs[i].rs2));
      check($sformatf("v%0d ex_rd", i), 64'(ex_rd), 64'(vecs[i].rd));
      check($sformatf("v%0d ex_funct", i), 64'(ex_funct), 64'(vecs[i].funct));
      check($sformatf("v%0d ex_pc", i), ex_pc, 64'h1000 + 64'(i * 4));
    end

    // Back-to-back stream: addi then add
    @(posedge clk);
    #1 present(32'h00A00093, 64'h200);
    @(posedge clk);
    #1;
    check("stream addi valid", 64'(ex_valid), 64'd1);
    check("stream addi ctrl", 64'(ex_ctrl), 64'h0C0);
    check("stream addi imm", ex_imm, 64'd10);
    present(32'h002081B3, 64'h204);
    #1 check("stream add if_ready", 64'(if_ready), 64'd1);
    @(posedge clk);
    #1 if_valid = 1'b0;
    check("stream add valid", 64'(ex_valid), 64'd1);
    check("stream add ctrl", 64'(ex_ctrl), 64'h080);
    check("stream add rd", 64'(ex_rd), 64'd3);
    check("stream add pc", ex_pc, 64'h204);

    // Load-use: lw x2 then add x4,x2,x2 -> one bubble
    @(posedge clk);
    #1 present(32'h0000A103, 64'h300);
    @(posedge clk);
    #1 present(32'h00210233, 64'h304);
    #1;
    check("lu stall if_ready", 64'(if_ready), 64'd0);
    check("lu lw ctrl", 64'(ex_ctrl), 64'h0D8);
    @(posedge clk);
    #1;
    check("lu bubble ex_valid", 64'(ex_valid), 64'd0);
    check("lu bubble if_ready", 64'(if_ready), 64'd1);
    @(posedge clk);
    #1 if_valid = 1'b0;
    check("lu add ex_valid", 64'(ex_valid), 64'd1);
    check("lu add rd", 64'(ex_rd), 64'd4);
    check("lu add pc", ex_pc, 64'h304);

    // Load to x0 never interlocks
    @(posedge clk);
    #1 present(32'h0000A003, 64'h400);
    @(posedge clk);
    #1 present(32'h00000233, 64'h404);
    #1 check("x0 if_ready", 64'(if_ready), 64'd1);
    @(posedge clk);
    #1 if_valid = 1'b0;
    check("x0 add ex_valid", 64'(ex_valid), 64'd1);
    check("x0 add rd", 64'(ex_rd), 64'd4);

    // Back-pressure for 3 cycles, then flush drops the held and offered instruction
    @(posedge clk);
    #1 ex_ready = 1'b0;
    present(32'h00A00093, 64'h500);
    @(posedge clk);
    #1 present(32'h002081B3, 64'h504);
    for (int k = 0; k < 3; k++) begin
      #1 check($sformatf("bp%0d if_ready", k), 64'(if_ready), 64'd0);
      @(posedge clk);
      #1;
      check($sformatf("bp%0d ex_valid", k), 64'(ex_valid), 64'd1);
      check($sformatf("bp%0d ex_ctrl", k), 64'(ex_ctrl), 64'h0C0);
      check($sformatf("bp%0d ex_imm", k), ex_imm, 64'd10);
      check($sformatf("bp%0d ex_pc", k), ex_pc, 64'h500);
    end
    flush = 1'b1;
    #1 check("flush if_ready", 64'(if_ready), 64'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    if_valid = 1'b0;
    ex_ready = 1'b1;
    check("flush ex_valid", 64'(ex_valid), 64'd0);
    @(posedge clk);
    #1 check("flush dropped", 64'(ex_valid), 64'd0);

`ifdef DECODE_PERF_CNT_EN
    check("perf_illegal", 64'(perf_illegal), 64'd2);
    check("perf_bubble", 64'(perf_bubble), 64'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/riscv_decode_stage.md
Name: riscv_decode_stage

Overview:
- Registered RV32I/RV64I main-control decode stage that generalises the combinational opcode decoder.
- Adds:
  - XLEN parametrisation;
  - LUI, AUIPC, OP-IMM and illegal-opcode decode;
  - immediate generation;
  - a valid/ready pipeline register toward EX;
  - a load-use interlock that inserts bubbles;
  - a synchronous flush.
- Sits between the IF/ID buffer and the EX stage of the pipelined core.

Parameters:
- XLEN, 32, datapath width (32 or 64); immediates are sign-extended to XLEN.
- RF_AW, 5, register-file address width.

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous active-high reset
- if_valid  input  1  instruction presented
- if_ready  output  1  stage accepts instruction this cycle
- if_inst  input  32  instruction word
- if_pc  input  XLEN  instruction PC
- flush  input  1  synchronous kill (branch mispredict/trap)
- ex_valid  output  1  registered decode result valid
- ex_ready  input  1  EX consumes result this cycle
- ex_pc  output  XLEN  registered PC
- ex_rs1, ex_rs2, ex_rd  output  RF_AW each  register indices
- ex_imm  output  XLEN  sign-extended immediate
- ex_funct  output  4  {inst[30], inst[14:12]}
- ex_ctrl  output  10  {illegal, auipc, lui, regwrite, alusrc, memwrite, memtoreg, memread, branch, jal, jalr} minus illegal, i.e. bit9=auipc, bit8=lui, bit7=regwrite, bit6=alusrc, bit5=memwrite, bit4=memtoreg, bit3=memread, bit2=branch, bit1=jal, bit0=jalr
- ex_illegal  output  1  unsupported opcode or inst[1:0]!=2'b11

Behaviour:
- Reset (asynchronous, rst=1): ex_valid=0, ex_ctrl=0, ex_illegal=0, ex_pc/ex_imm/ex_rs*/ex_rd/ex_funct=0. Outputs stay at these values until the first transfer after rst deasserts.
- Combinational decode of if_inst, ctrl bits set per opcode; all other bits 0:
  - R 0110011: regwrite.
  - OP-IMM 0010011: regwrite, alusrc.
  - LOAD 0000011: memread, memtoreg, alusrc, regwrite.
  - STORE 0100011: memwrite, alusrc.
  - BRANCH 1100011: branch.
  - JAL 1101111: jal, regwrite.
  - JALR 1100111: jalr, alusrc, regwrite.
  - LUI 0110111: lui, regwrite, alusrc.
  - AUIPC 0010111: auipc, regwrite, alusrc.
  - Other opcode, or inst[1:0]!=11: ctrl=0 and illegal=1.
- Immediate selection:
  - I-type for OP-IMM/LOAD/JALR, S for STORE, B for BRANCH, U for LUI/AUIPC, J for JAL, 0 otherwise.
  - Sign bit is inst[31], replicated up to XLEN-1.
  - U-type is {inst[31:12], 12'b0} sign-extended.
- Source usage:
  - uses_rs1 for R/OP-IMM/LOAD/STORE/BRANCH/JALR.
  - uses_rs2 for R/STORE/BRANCH.
- hazard = if_valid & ex_valid & ex_ctrl.memread & (ex_rd!=0) & ((uses_rs1 & rs1==ex_rd) | (uses_rs2 & rs2==ex_rd)).
- if_ready = ~flush & ~hazard & (~ex_valid | ex_ready).
- Register update, priority order:
  1. flush=1: ex_valid<=0, other fields don't-care/held.
  2. Else if if_valid & if_ready: load all decoded fields, ex_valid<=1.
  3. Else if ex_ready | ~ex_valid: ex_valid<=0. A hazard with ex_ready=1 yields exactly one bubble, which clears the hazard next cycle.
  4. Else hold all outputs.
- Latency: 1 cycle from accepted instruction to ex_valid; throughput 1/cycle with no hazard.
- Outputs are stable while ex_valid=1 & ex_ready=0.
- Simultaneous flush and if_valid: the instruction is not accepted (if_ready=0).
- Reset mid-stream discards the held instruction.

Optional Feature:
- DECODE_PERF_CNT_EN
- Defined:
  - Adds outputs perf_bubble[31:0] and perf_illegal[31:0], both reset to 0.
  - perf_bubble increments on each cycle where hazard & ex_ready & ~flush.
  - perf_illegal increments on each accepted illegal instruction.
  - Both wrap at 2^32-1 to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with ex_valid=1 -> ex_valid=0 and ex_ctrl=0 immediately; no output change until the next accepted instruction.
- Stream without stalls: 0x00A00093 (addi x1,x0,10) then 0x002081B3 (add x3,x1,x2), ex_ready=1 -> consecutive ex_valid cycles.
  - addi: ex_ctrl=0x0C0, ex_imm=10.
  - add: ex_ctrl=0x080, rd=3.
- Load-use interlock: 0x0000A103 (lw x2,0(x1)) then 0x00210233 (add x4,x2,x2) -> if_ready=0 for one cycle, one bubble (ex_valid=0), then add issues. Repeat with rd=x0 -> no bubble.
- Immediates:
  - sw 0xFE112E23: ex_imm=-4.
  - beq 0xFE000EE3: ex_imm=-4.
  - lui 0x800000B7: ex_imm=0xFFFFFFFF80000000 at XLEN=64.
  - jal 0x0080006F: ex_imm=8.
- Back-pressure and flush: hold ex_ready=0 for 3 cycles -> outputs stable, if_ready=0. Then assert flush -> ex_valid=0 next cycle; instruction presented with flush is dropped.
- Illegal: 0xFFFFFFFF -> ex_illegal=1, ex_ctrl=0, ex_valid=1. With DECODE_PERF_CNT_EN defined, perf_illegal=1.
